// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a core port and a loader/DMA port share one
// synchronous-read memory. Each access takes IDLE -> ACCESS -> RESPOND, and
// ties between the two ports are broken by alternating grants.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // core request/response port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    // loader/DMA request/response port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;

    logic              grant;
    logic              in_access;
    logic              in_respond;
    logic [DATA_W-1:0] resp_data;

    // Next-state logic: arbitrate in IDLE and capture the winning request so
    // later changes on the request ports cannot disturb the access.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        grant        = OWN_CPU;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    // On a tie the port that did not win last time goes first.
                    if (cpu_req && dma_req) begin
                        grant = ~last_grant_q;
                    end else begin
                        grant = dma_req ? OWN_DMA : OWN_CPU;
                    end
                    owner_d      = grant;
                    last_grant_d = grant;
                    we_d         = (grant == OWN_DMA) ? dma_we    : cpu_we;
                    addr_d       = (grant == OWN_DMA) ? dma_addr  : cpu_addr;
                    wdata_d      = (grant == OWN_DMA) ? dma_wdata : cpu_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset favours the core on the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= OWN_DMA;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset silences the memory strobes and ready pulses immediately.
    always_comb begin
        in_access  = (state_q == ACCESS);
        in_respond = (state_q == RESPOND);
        resp_data  = we_q ? '0 : mem_rdata;

        mem_en     = in_access;
        mem_we     = in_access & we_q;
        mem_addr   = in_access ? addr_q  : '0;
        mem_wdata  = in_access ? wdata_q : '0;

        cpu_ready  = in_respond & (owner_q == OWN_CPU);
        dma_ready  = in_respond & (owner_q == OWN_DMA);
        cpu_rdata  = cpu_ready ? resp_data : '0;
        dma_rdata  = dma_ready ? resp_data : '0;

        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// schedule-based reference model (grant cycle + fixed offsets).
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ready, dma_ready, mem_en, mem_we, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Power-up contents of the memory; 0x10 holds the known read pattern.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {8'h5A, a, ~a, 8'hC3};
    endfunction

    // Bench memory: synchronous read, garbage on the data bus when not reading.
    logic [31:0] bmem [256];
    bit          bvalid [256];
    bit          mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) bvalid[i] <= 1'b0;
            mem_inited <= 1'b1;
        end else if (mem_en && mem_we) begin
            bmem[mem_addr[7:0]]   <= mem_wdata;
            bvalid[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= bvalid[mem_addr[7:0]] ? bmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
        else
            mem_rdata <= $urandom;
    end

    // Reference model state: the cycle of the last grant plus what was granted.
    int          cyc;
    int          g_cyc;
    int          next_free;
    logic        g_owner, g_we, last_m;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] m_mem [256];
    bit          m_valid [256];
    int          resp_cyc [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [7:0] a);
        return m_valid[a] ? m_mem[a] : init_val(a);
    endfunction

    // One model cycle: compare every output, then decide whether a grant is made.
    task automatic model_cycle();
        logic        acc, rsp, win;
        logic [31:0] rd;
        if (reset) begin
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chkw("rst_mem_addr", mem_addr, 32'h0);
            chkw("rst_mem_wdata", mem_wdata, 32'h0);
            chk1("rst_cpu_ready", cpu_ready, 1'b0);
            chkw("rst_cpu_rdata", cpu_rdata, 32'h0);
            chk1("rst_dma_ready", dma_ready, 1'b0);
            chkw("rst_dma_rdata", dma_rdata, 32'h0);
            chk1("rst_busy", busy, 1'b0);
            g_cyc     = -100;
            next_free = 0;
            last_m    = 1'b1;
            resp_cyc  = '{-10, -10};
            return;
        end
        acc = (cyc == g_cyc + 1);
        rsp = (cyc == g_cyc + 2);
        rd  = (rsp && !g_we) ? mread(g_addr[7:0]) : 32'h0;
        chk1("mem_en", mem_en, acc);
        chk1("mem_we", mem_we, acc && g_we);
        chkw("mem_addr", mem_addr, acc ? g_addr : 32'h0);
        chkw("mem_wdata", mem_wdata, acc ? g_wdata : 32'h0);
        chk1("busy", busy, acc || rsp);
        chk1("cpu_ready", cpu_ready, rsp && !g_owner);
        chkw("cpu_rdata", cpu_rdata, (rsp && !g_owner) ? rd : 32'h0);
        chk1("dma_ready", dma_ready, rsp && g_owner);
        chkw("dma_rdata", dma_rdata, (rsp && g_owner) ? rd : 32'h0);
        if (acc && g_we) begin
            m_mem[g_addr[7:0]]   = g_wdata;
            m_valid[g_addr[7:0]] = 1'b1;
        end
        if (cyc >= next_free && (cpu_req || dma_req)) begin
            win       = (cpu_req && dma_req) ? !last_m : dma_req;
            last_m    = win;
            g_owner   = win;
            g_cyc     = cyc;
            next_free = cyc + 3;
            g_we      = win ? dma_we    : cpu_we;
            g_addr    = win ? dma_addr  : cpu_addr;
            g_wdata   = win ? dma_wdata : cpu_wdata;
            resp_cyc[win ? 1 : 0] = cyc + 2;
        end
    endtask

    // Finish the current cycle (model check at the falling edge) and land
    // just after the next rising edge, where inputs for the new cycle are set.
    task automatic step();
        @(negedge clk);
        model_cycle();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Random requester: holds its request until granted, may withdraw or
    // scramble fields once granted, and may re-request right after its ready.
    task automatic agent(input int a, inout logic req, inout logic we,
                         inout logic [31:0] addr, inout logic [31:0] wd);
        if (cyc == resp_cyc[a] + 1) begin
            if ($urandom_range(0, 3) != 0) begin
                req = 1'b0;
            end else begin
                we   = ($urandom_range(0, 1) == 1);
                addr = 32'($urandom_range(0, 7)) << 4;
                wd   = $urandom;
            end
        end else if (cyc == resp_cyc[a] - 1) begin
            case ($urandom_range(0, 3))
                0: req = 1'b0;
                1: begin
                    we   = ($urandom_range(0, 1) == 1);
                    addr = 32'($urandom_range(0, 7)) << 4;
                    wd   = $urandom;
                end
                default: ;
            endcase
        end else if (!req && $urandom_range(0, 2) == 0) begin
            req  = 1'b1;
            we   = ($urandom_range(0, 1) == 1);
            addr = 32'($urandom_range(0, 7)) << 4;
            wd   = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        cyc = 0; g_cyc = -100; next_free = 0; last_m = 1'b1;
        resp_cyc = '{-10, -10};

        // Reset state
        @(posedge clk); #1;
        chk1("por_busy", busy, 1'b0);
        chk1("por_mem_en", mem_en, 1'b0);
        chk1("por_cpu_ready", cpu_ready, 1'b0);
        step();
        reset = 1'b0;

        // Core read of 0x10, address changed to 0x40 mid-access
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        chk1("d40_idle_busy", busy, 1'b0);
        step();
        cpu_addr = 32'h40;
        #1;
        chk1("d40_mem_en", mem_en, 1'b1);
        chkw("d43_mem_addr", mem_addr, 32'h10);
        step();
        chk1("d40_cpu_ready", cpu_ready, 1'b1);
        chkw("d40_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk1("d40_dma_ready", dma_ready, 1'b0);
        cpu_req = 1'b0;
        step();
        chk1("d40_back_idle", busy, 1'b0);
        step();

        // DMA write 0x12345678 to 0x20
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        step();
        chk1("d41_mem_we", mem_we, 1'b1);
        chkw("d41_mem_addr", mem_addr, 32'h20);
        chkw("d41_mem_wdata", mem_wdata, 32'h12345678);
        step();
        chk1("d41_dma_ready", dma_ready, 1'b1);
        chkw("d41_dma_rdata", dma_rdata, 32'h0);
        dma_req = 1'b0;
        step();
        step();

        // DMA read of 0x20 withdrawn during the access still completes
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; dma_wdata = 32'h0;
        step();
        dma_req = 1'b0;
        step();
        chk1("d45_dma_ready", dma_ready, 1'b1);
        chkw("d45_dma_rdata", dma_rdata, 32'h12345678);
        step();
        chk1("d45_idle1", busy, 1'b0);
        step();
        chk1("d45_idle2", busy, 1'b0);
        chk1("d45_no_grant", mem_en, 1'b0);
        step();

        // Core access aborted by reset in ACCESS
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        step();
        chk1("d44_in_access", mem_en, 1'b1);
        reset = 1'b1;
        #1;
        chk1("d44_mem_en_drop", mem_en, 1'b0);
        chk1("d44_busy_drop", busy, 1'b0);
        chk1("d44_no_ready", cpu_ready, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Both requesting continuously: CPU first, then strict alternation
        cpu_addr = 32'h10; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int i = 0; i < 13; i++) begin
            chk1("d42_cpu_ready", cpu_ready, (i == 2) || (i == 8));
            chk1("d42_dma_ready", dma_ready, (i == 5) || (i == 11));
            step();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            agent(0, cpu_req, cpu_we, cpu_addr, cpu_wdata);
            agent(1, dma_req, dma_we, dma_addr, dma_wdata);
            step();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
